// File: rtl/aes_mode_ctrl.sv
// Block-cipher mode controller: sequences ECB/CBC/CTR messages one block at a
// time through an external AES core, with ready/valid on both data sides.
module aes_mode_ctrl #(
  parameter int LEN_W = 16,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic [LEN_W-1:0] cfg_nblk,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             core_start,
  output logic [127:0]     core_key,
  output logic [127:0]     core_din,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic [127:0]     core_dout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] blk_cnt
);

  localparam logic [1:0] MODE_ECB = 2'd0;
  localparam logic [1:0] MODE_CBC = 2'd1;
  localparam logic [1:0] MODE_CTR = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  // Only the low CTR_W bits of the counter take part in the increment.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    OUT,
    FIN
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       ctr_q, ctr_d;
  logic [LEN_W-1:0]   nblk_q, nblk_d;
  logic [127:0]       blk_q, blk_d;
  logic [127:0]       res_q, res_d;
  logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               err_q, err_d;

  logic [LEN_W:0]     blk_cnt_inc;
  logic               more_blocks;
  logic [127:0]       ctr_inc;

  // The core's own busy flag is informational; sequencing relies on core_done.
  logic               unused_core_busy;
  assign unused_core_busy = core_busy;

  assign blk_cnt_inc = {1'b0, blk_cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign more_blocks = blk_cnt_inc < {1'b0, nblk_q};
  assign ctr_inc     = ctr_q + 128'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ECB;
      key_q     <= '0;
      chain_q   <= '0;
      ctr_q     <= '0;
      nblk_q    <= '0;
      blk_q     <= '0;
      res_q     <= '0;
      blk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      key_q     <= key_d;
      chain_q   <= chain_d;
      ctr_q     <= ctr_d;
      nblk_q    <= nblk_d;
      blk_q     <= blk_d;
      res_q     <= res_d;
      blk_cnt_q <= blk_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    key_d     = key_q;
    chain_d   = chain_q;
    ctr_d     = ctr_q;
    nblk_d    = nblk_q;
    blk_d     = blk_q;
    res_d     = res_q;
    blk_cnt_d = blk_cnt_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          mode_d    = cfg_mode;
          key_d     = cfg_key;
          chain_d   = cfg_iv;
          ctr_d     = cfg_iv;
          nblk_d    = cfg_nblk;
          blk_cnt_d = '0;
          err_d     = (cfg_mode == MODE_BAD);
          // Empty or illegal messages skip straight to completion.
          if ((cfg_nblk == '0) || (cfg_mode == MODE_BAD)) begin
            state_d = FIN;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (in_valid) begin
          blk_d   = in_data;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        state_d = WAIT;
        if (mode_q == MODE_CTR) begin
          ctr_d = (ctr_inc & CTR_MASK) | (ctr_q & ~CTR_MASK);
        end
      end

      WAIT: begin
        if (core_done) begin
          if (mode_q == MODE_CTR) begin
            res_d = core_dout ^ blk_q;
          end else begin
            res_d = core_dout;
          end
          if (mode_q == MODE_CBC) begin
            chain_d = core_dout;
          end
          state_d = OUT;
        end
      end

      OUT: begin
        if (out_ready) begin
          blk_cnt_d = blk_cnt_inc[LEN_W-1:0];
          state_d   = more_blocks ? LOAD : FIN;
        end
      end

      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_din = '0;
    if (state_q == ISSUE) begin
      case (mode_q)
        MODE_CBC: core_din = blk_q ^ chain_q;
        MODE_CTR: core_din = ctr_q;
        default:  core_din = blk_q;
      endcase
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign core_start = (state_q == ISSUE);
  assign core_key   = key_q;
  assign out_valid  = (state_q == OUT);
  assign out_data   = res_q;
  assign out_last   = (state_q == OUT) && !more_blocks;
  assign busy       = (state_q == LOAD) || (state_q == ISSUE) ||
                      (state_q == WAIT) || (state_q == OUT);
  assign done       = (state_q == FIN);
  assign err        = (state_q == FIN) && err_q;
  assign blk_cnt    = blk_cnt_q;

endmodule
